// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial word transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1
  } tx_state_t;

  localparam int   SER_W_DEFAULT = 8;
  localparam logic SER_IDLE_BIT  = 1'b0;

endpackage

// File: rtl/serial_word_tx.sv
// Parallel-to-serial transmitter with a one-word holding slot so that
// back-to-back words leave on sout with no idle bit between them.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int   W         = SER_W_DEFAULT,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         word_done
);

  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  tx_state_t     state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [W-1:0]  hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          xfer;
  logic [W-1:0]  shifted;

  assign din_ready = !hold_full_q;
  assign xfer      = din_valid && din_ready;
  assign shifted   = MSB_FIRST ? {shreg_q[W-2:0], 1'b0} : {1'b0, shreg_q[W-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= TX_IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    case (state_q)
      TX_IDLE: begin
        if (xfer) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (cnt_q == LAST) begin
          // Reload from the slot first; a new transfer cannot coincide with a full slot.
          if (hold_full_q) begin
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else if (xfer) begin
            shreg_d = din;
            cnt_d   = '0;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CW'(1);
          if (xfer) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign sout_valid = (state_q == TX_SHIFT);
  assign sout       = sout_valid ? (MSB_FIRST ? shreg_q[W-1] : shreg_q[0]) : IDLE_BIT;
  assign word_done  = sout_valid && (cnt_q == LAST);
  assign busy       = sout_valid || hold_full_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench: two transmitter instances (MSB-first and LSB-first)
// compared every cycle against a bit-queue model, plus a 10010 detector on sout.
module tb_serial_word_tx;
  import serial_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic din_ready, sout, sout_valid, busy, word_done;
  logic din_ready_l, sout_l, sout_valid_l, busy_l, word_done_l;

  int checks = 0;
  int errors = 0;
  int detCount = 0;

  // Expected serial bits still to appear, head = bit on sout this cycle.
  bit expQ[$];
  bit expL[$];

  logic [4:0] detHist;
  logic       detOut;

  serial_word_tx #(.W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sout(sout), .sout_valid(sout_valid),
    .busy(busy), .word_done(word_done)
  );

  serial_word_tx #(.W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_l), .sout(sout_l), .sout_valid(sout_valid_l),
    .busy(busy_l), .word_done(word_done_l)
  );

  always #5 clk = ~clk;

  // Moore 10010 detector fed from the MSB-first serial output.
  always @(posedge clk or negedge rst) begin
    if (!rst) detHist <= '0;
    else      detHist <= {detHist[3:0], sout};
  end
  assign detOut = (detHist == 5'b10010);

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare both instances against the queue model; the slot is full once
  // more than one word's worth of bits is pending.
  task automatic checkOutput(input string tag);
    int n;
    n = expQ.size();
    chkBit({tag, ":sout"},       sout,       (n > 0) ? logic'(expQ[0]) : 1'b0);
    chkBit({tag, ":sout_valid"}, sout_valid, n > 0);
    chkBit({tag, ":din_ready"},  din_ready,  n <= W);
    chkBit({tag, ":busy"},       busy,       n > 0);
    chkBit({tag, ":word_done"},  word_done,  (n > 0) && ((n % W) == 1));
    n = expL.size();
    chkBit({tag, ":sout_l"},       sout_l,       (n > 0) ? logic'(expL[0]) : 1'b0);
    chkBit({tag, ":sout_valid_l"}, sout_valid_l, n > 0);
    chkBit({tag, ":din_ready_l"},  din_ready_l,  n <= W);
    chkBit({tag, ":busy_l"},       busy_l,       n > 0);
    chkBit({tag, ":word_done_l"},  word_done_l,  (n > 0) && ((n % W) == 1));
    if (detOut) detCount++;
  endtask

  // One clock: drive inputs, advance the model on the edge, check at negedge.
  task automatic applyStimulus(input string tag, input logic v, input logic [W-1:0] d);
    bit accept;
    din_valid = v;
    din       = d;
    @(posedge clk);
    accept = v && (expQ.size() <= W) && rst;
    if (expQ.size() > 0) void'(expQ.pop_front());
    if (expL.size() > 0) void'(expL.pop_front());
    if (accept) begin
      for (int i = W - 1; i >= 0; i--) expQ.push_back(d[i]);
      for (int i = 0; i < W; i++)      expL.push_back(d[i]);
    end
    @(negedge clk);
    checkOutput(tag);
  endtask

  // Asynchronous reset pulled mid-cycle, checked before any clock edge.
  task automatic doReset(input string tag);
    din_valid = 1'b0;
    #2 rst = 1'b0;
    expQ.delete();
    expL.delete();
    #1 checkOutput({tag, ":async"});
    @(negedge clk);
    checkOutput({tag, ":held"});
    rst = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    #1 checkOutput("por");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) applyStimulus("idle0", 1'b0, '0);

    doReset("reset_idle");
    applyStimulus("idle1", 1'b0, '0);

    applyStimulus("a5_xfer", 1'b1, 8'hA5);
    repeat (10) applyStimulus("a5_bits", 1'b0, '0);

    applyStimulus("b2b_w1", 1'b1, 8'h90);
    applyStimulus("b2b_w2", 1'b1, 8'h12);
    repeat (18) applyStimulus("b2b_bits", 1'b0, '0);

    applyStimulus("w01_xfer", 1'b1, 8'h01);
    repeat (9) applyStimulus("w01_bits", 1'b0, '0);

    applyStimulus("ff_xfer", 1'b1, 8'hFF);
    repeat (3) applyStimulus("ff_bits", 1'b0, '0);
    doReset("reset_mid");
    repeat (2) applyStimulus("post_rst", 1'b0, '0);
    applyStimulus("zero_xfer", 1'b1, 8'h00);
    repeat (10) applyStimulus("zero_bits", 1'b0, '0);

    repeat (6) applyStimulus("det_pre", 1'b0, '0);
    detCount = 0;
    applyStimulus("det_xfer", 1'b1, 8'h92);
    repeat (16) applyStimulus("det_bits", 1'b0, '0);
    chkInt("det_pulses", detCount, 2);

    for (int c = 0; c < 300; c++) begin
      applyStimulus("rand", ($urandom % 4) != 0, W'($urandom));
      if (c == 150) doReset("reset_rand");
    end
    repeat (20) applyStimulus("drain", 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
Parallel-to-serial transmitter directly upstream of the Moore sequence detectors; its serial output drives a detector's single-bit input j.
Accepts W-bit words over a valid/ready handshake.
Shifts each word out one bit per clock, with a one-word holding slot so consecutive words stream without gaps.
Drives a fixed idle bit when it has no data.

Parameters:
W, 8, word width in bits; legal range W >= 2
MSB_FIRST, 1, 1 = transmit bit W-1 first; 0 = transmit bit 0 first
IDLE_BIT, 1'b0, value driven on sout when no word is being shifted

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
din  input  W  parallel word to transmit
din_valid  input  1  din holds a valid word
din_ready  output  1  block can accept a word this cycle
sout  output  1  serial bit stream; connects to the detector's j input
sout_valid  output  1  sout carries a data bit this cycle
busy  output  1  a word is shifting, or the holding slot is occupied
word_done  output  1  high during the last bit of each word

Behaviour:
- Storage: shift register shreg[W-1:0]; holding register hold[W-1:0] with flag hold_full; bit counter cnt, width $clog2(W); state register.
- States:
  - IDLE: nothing shifting.
  - SHIFT: sout = current bit of shreg.
- Handshake:
  - din_ready = !hold_full (combinational).
  - A transfer occurs at a rising edge where din_valid && din_ready.
  - din_valid may drop without a transfer. No other protocol obligation.
- IDLE, transfer at edge k: shreg <= din, cnt <= 0, state <= SHIFT. The first bit appears on sout in the cycle after edge k (latency 1 clock).
- SHIFT, cnt < W-1: each edge shifts shreg by one bit toward the output end and increments cnt. A transfer on the same edge writes hold and sets hold_full.
- SHIFT, cnt == W-1 (last-bit edge):
  - If hold_full: shreg <= hold, clear hold_full, cnt <= 0, stay in SHIFT. No bubble.
  - Else if a transfer occurs on this edge: shreg <= din directly, cnt <= 0, stay in SHIFT. No bubble.
  - Else: state <= IDLE.
  - A transfer and a full hold cannot coincide, because din_ready is 0 whenever hold_full is set.
- Outputs (combinational from registers):
  - sout = (state==SHIFT) ? (MSB_FIRST ? shreg[W-1] : shreg[0]) : IDLE_BIT.
  - sout_valid = (state==SHIFT).
  - word_done = (state==SHIFT && cnt==W-1). Exactly one cycle per word.
  - busy = (state==SHIFT) || hold_full.
- Throughput: continuous streaming at 1 bit/clock. din_ready stays low while the holding slot is occupied.
- Reset values (rst low, applied immediately, asynchronous):
  - state = IDLE, shreg = 0, hold = 0, hold_full = 0, cnt = 0.
  - Therefore sout = IDLE_BIT, sout_valid = 0, din_ready = 1, busy = 0, word_done = 0.
- Reset mid-word: the partially sent word and any held word are discarded, not replayed. After rst releases, the next transfer starts a clean word at bit 0.
- No X propagation: din is sampled only on a transfer edge.

Decomposition:
- Shared package serial_pkg holds:
  - enum tx_state_t {TX_IDLE, TX_SHIFT} (2-bit logic encoding);
  - constant SER_W_DEFAULT = 8;
  - constant SER_IDLE_BIT = 1'b0.
- Single module; no sub-module. The holding register is too small to justify a separate FIFO.

Test Plan:
1. Assert rst low mid-simulation with clocks running -> immediately sout=0, sout_valid=0, din_ready=1, busy=0, word_done=0.
2. Send din=8'hA5 with MSB_FIRST=1, transferred at edge 1:
   - sout = 1,0,1,0,0,1,0,1 over cycles 2-9, with sout_valid high for exactly those 8 cycles;
   - word_done high only in cycle 9;
   - sout=0 from cycle 10.
3. Send 8'h90 then 8'h12 back to back, din_valid held high:
   - 16 gapless bits 1001000000010010;
   - din_ready low from the edge after the second transfer until the last-bit edge of word 1;
   - word_done pulses in cycles 9 and 17.
4. MSB_FIRST=0, din=8'h01 -> sout = 1,0,0,0,0,0,0,0.
5. Send 8'hFF, pull rst low after 3 bits, release, then send 8'h00:
   - sout goes to IDLE_BIT asynchronously on reset;
   - the remaining 1s never appear;
   - the next word produces 8 zeros with sout_valid high.
6. Integration: drive a 10010 Moore detector from sout and send 8'h92 (10010010) -> detector output pulses twice (after bit 5 and after bit 8, overlap), and never during idle 0s.
